// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard and the issue window.
// Register IDs and the latency encoding live here so both sides agree on them.
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int LAT_W    = 3;

  typedef logic [REG_W-1:0] reg_id_t;
  typedef logic [LAT_W-1:0] lat_t;

  // A latency of zero marks a variable-latency op that completes through writeback.
  localparam lat_t LAT_VAR = '0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_id_t id);
    logic [NUM_REGS-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard entry: pending-write state for a single architectural register,
// with its fixed-latency countdown and its one-cycle completion pulse.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic set_i,
  input  lat_t lat_i,
  input  logic wb_hit_i,
  output logic busy_o,
  output logic var_o,
  output logic wakeup_o
);

  logic busy_q, busy_d;
  logic var_q,  var_d;
  lat_t cnt_q,  cnt_d;
  logic fixed_done;
  logic var_done;

  assign fixed_done = busy_q && !var_q && (cnt_q == lat_t'(1));
  assign var_done   = busy_q &&  var_q && wb_hit_i;

  // A completion that coincides with reset belongs to a discarded write.
  assign wakeup_o = reset_n && (fixed_done || var_done);
  assign busy_o   = busy_q;
  assign var_o    = var_q;

  // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    if (set_i) begin
      busy_d = 1'b1;
      if (lat_i == LAT_VAR) begin
        var_d = 1'b1;
      end else begin
        var_d = 1'b0;
        cnt_d = lat_i;
      end
    end else if (fixed_done) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (var_done) begin
      busy_d = 1'b0;
      var_d  = 1'b0;
    end else if (busy_q && !var_q && (cnt_q > lat_t'(1))) begin
      cnt_d = cnt_q - lat_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every entry samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      var_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      var_q  <= var_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: stalls dispatch on RAW/WAW hazards against in-flight writes,
// tracks fixed- and variable-latency completion, and flags stray writebacks.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                disp_valid,
  input  reg_id_t             disp_src0,
  input  reg_id_t             disp_src1,
  input  reg_id_t             disp_dst,
  input  logic                disp_wr,
  input  lat_t                disp_lat,
  output logic                disp_ready,
  input  logic                wb_valid,
  input  reg_id_t             wb_dst,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] wakeup,
  output logic                wb_err
);

  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] var_vec;
  logic [NUM_REGS-1:0] wake_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] wb_hit_vec;
  logic                accept;
  logic                wb_stray;
  logic                wb_err_q, wb_err_d;

  // Hazard check looks only at registered busy; a source completing this cycle still stalls.
  assign disp_ready = !busy_vec[disp_src0] && !busy_vec[disp_src1] &&
                      !(disp_wr && busy_vec[disp_dst]);
  assign accept     = disp_valid && disp_ready;

  always_comb begin
    set_vec    = '0;
    wb_hit_vec = '0;
    if (accept && disp_wr && (disp_dst != '0)) set_vec = reg_onehot(disp_dst);
    if (wb_valid) wb_hit_vec = reg_onehot(wb_dst);
  end

  // Register 0 is hardwired free: no entry, never busy, never wakes.
  assign busy_vec[0] = 1'b0;
  assign var_vec[0]  = 1'b0;
  assign wake_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry u_entry (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_i    (set_vec[r]),
      .lat_i    (disp_lat),
      .wb_hit_i (wb_hit_vec[r]),
      .busy_o   (busy_vec[r]),
      .var_o    (var_vec[r]),
      .wakeup_o (wake_vec[r])
    );
  end

  // A writeback is legal only against a pending variable-latency write.
  assign wb_stray = wb_valid && !(busy_vec[wb_dst] && var_vec[wb_dst]);
  assign wb_err_d = wb_err_q || wb_stray;

  always_ff @(posedge clk) begin
    if (!reset_n) wb_err_q <= 1'b0;
    else          wb_err_q <= wb_err_d;
  end

  assign busy   = busy_vec;
  assign wakeup = wake_vec;
  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a cycle-count reference model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                disp_valid;
  reg_id_t             disp_src0, disp_src1, disp_dst;
  logic                disp_wr;
  lat_t                disp_lat;
  logic                disp_ready;
  logic                wb_valid;
  reg_id_t             wb_dst;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wakeup;
  logic                wb_err;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .disp_valid (disp_valid),
    .disp_src0  (disp_src0),
    .disp_src1  (disp_src1),
    .disp_dst   (disp_dst),
    .disp_wr    (disp_wr),
    .disp_lat   (disp_lat),
    .disp_ready (disp_ready),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .busy       (busy),
    .wakeup     (wakeup),
    .wb_err     (wb_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles of a fixed-latency write, or a pending variable write.
  int rem [NUM_REGS];
  bit pv  [NUM_REGS];
  bit err_m;

  // Values seen at the most recent sample point, for directed checks.
  logic [NUM_REGS-1:0] s_busy, s_wake;
  logic                s_ready, s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      rem[r] = 0;
      pv[r]  = 1'b0;
    end
    err_m = 1'b0;
  endtask

  task automatic drive(input logic v, input int s0, input int s1, input int d,
                       input logic wr, input int lat);
    disp_valid = v;
    disp_src0  = reg_id_t'(s0);
    disp_src1  = reg_id_t'(s1);
    disp_dst   = reg_id_t'(d);
    disp_wr    = wr;
    disp_lat   = lat_t'(lat);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 0);
    wb_valid = 1'b0;
    wb_dst   = '0;
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step();
    logic [NUM_REGS-1:0] b_exp, w_exp;
    logic                r_exp;
    @(negedge clk);
    for (int r = 0; r < NUM_REGS; r++) begin
      b_exp[r] = (rem[r] > 0) || pv[r];
      w_exp[r] = reset_n && ((rem[r] == 1) || (pv[r] && wb_valid && (int'(wb_dst) == r)));
    end
    r_exp = !b_exp[disp_src0] && !b_exp[disp_src1] && !(disp_wr && b_exp[disp_dst]);
    chk("busy",       32'(busy),       32'(b_exp));
    chk("wakeup",     32'(wakeup),     32'(w_exp));
    chk("disp_ready", 32'(disp_ready), 32'(r_exp));
    chk("wb_err",     32'(wb_err),     32'(err_m));
    s_busy  = busy;
    s_wake  = wakeup;
    s_ready = disp_ready;
    s_err   = wb_err;
    if (!reset_n) begin
      model_clear();
    end else begin
      if (wb_valid && !pv[wb_dst]) err_m = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_exp[r]) begin
          rem[r] = 0;
          pv[r]  = 1'b0;
        end else if (rem[r] > 1) begin
          rem[r] = rem[r] - 1;
        end
      end
      if (disp_valid && r_exp && disp_wr && (disp_dst != '0)) begin
        if (disp_lat != '0) rem[disp_dst] = int'(disp_lat);
        else                pv[disp_dst]  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int                  stalls;
    logic [NUM_REGS-1:0] acc_busy, acc_wake;

    model_clear();
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("reset_busy",  32'(s_busy),  32'h0);
    chk("reset_ready", 32'(s_ready), 32'h1);

    // Fixed latency 2 into r3
    drive(1'b1, 1, 2, 3, 1'b1, 2);
    step();
    chk("t1_accept", 32'(s_ready), 32'h1);
    idle();
    step();
    chk("t1_busy_c1", 32'(s_busy[3]), 32'h1);
    step();
    chk("t1_wake_c2", 32'(s_wake[3]), 32'h1);
    step();
    chk("t1_busy_after", 32'(s_busy[3]), 32'h0);

    // RAW on r5 (lat 3): consumer stalls three cycles
    drive(1'b1, 0, 0, 5, 1'b1, 3);
    step();
    drive(1'b1, 5, 0, 0, 1'b0, 0);
    stalls = 0;
    step();
    for (int i = 0; i < 10 && !s_ready; i++) begin
      stalls++;
      step();
    end
    chk("t2_stalls", 32'(stalls), 32'd3);
    chk("t2_accept", 32'(s_ready), 32'h1);
    idle();

    // Variable latency on r4 completed by writeback
    drive(1'b1, 0, 0, 4, 1'b1, 0);
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    chk("t3_busy_held", 32'(s_busy[4]), 32'h1);
    wb_valid = 1'b1;
    wb_dst   = reg_id_t'(4);
    step();
    chk("t3_wake", 32'(s_wake[4]), 32'h1);
    idle();
    step();
    chk("t3_busy_clear", 32'(s_busy[4]), 32'h0);
    chk("t3_no_err",     32'(s_err),     32'h0);

    // Stray writeback to idle r6 is sticky until reset
    wb_valid = 1'b1;
    wb_dst   = reg_id_t'(6);
    step();
    idle();
    step();
    step();
    chk("t4_err_sticky", 32'(s_err),  32'h1);
    chk("t4_busy",       32'(s_busy), 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("t4_err_reset", 32'(s_err), 32'h0);

    // Writes to r0 are ignored; WAW on r7 stalls one cycle
    drive(1'b1, 0, 0, 0, 1'b1, 4);
    step();
    idle();
    acc_busy = '0;
    acc_wake = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc_busy |= s_busy;
      acc_wake |= s_wake;
    end
    chk("t5_r0_busy", 32'(acc_busy), 32'h0);
    chk("t5_r0_wake", 32'(acc_wake), 32'h0);
    drive(1'b1, 0, 0, 7, 1'b1, 1);
    step();
    chk("t5_first_accept", 32'(s_ready), 32'h1);
    step();
    chk("t5_waw_stall", 32'(s_ready),   32'h0);
    chk("t5_waw_wake",  32'(s_wake[7]), 32'h1);
    step();
    chk("t5_second_accept", 32'(s_ready), 32'h1);
    idle();
    step();
    chk("t5_second_wake", 32'(s_wake[7]), 32'h1);

    // Reset mid-flight discards pending r2 (fixed) and r3 (variable)
    drive(1'b1, 0, 0, 2, 1'b1, 7);
    step();
    drive(1'b1, 0, 0, 3, 1'b1, 0);
    step();
    idle();
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    acc_busy = '0;
    acc_wake = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      acc_busy |= s_busy;
      acc_wake |= s_wake;
    end
    chk("t6_busy",  32'(acc_busy), 32'h0);
    chk("t6_wake",  32'(acc_wake), 32'h0);
    chk("t6_ready", 32'(s_ready),  32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, NUM_REGS - 1)),
            int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << LAT_W) - 1)));
      wb_valid = 1'b0;
      wb_dst   = '0;
      if ($urandom_range(0, 2) == 0) begin
        wb_valid = 1'b1;
        wb_dst   = reg_id_t'($urandom_range(0, NUM_REGS - 1));
        for (int r = 1; r < NUM_REGS; r++) begin
          if (pv[r] && $urandom_range(0, 1) == 1) wb_dst = reg_id_t'(r);
        end
      end
      reset_n = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer side of the dependency check performed at issue: tracks which architectural registers have a write in flight.
- Gates dispatch of an instruction until its sources and destination are free.
- Broadcasts a one-cycle wakeup when each pending write completes.
- Sits between decode/dispatch and the issue window; the 3-bit register IDs match the issue window's.

Parameters:
- NUM_REGS, 8, number of architectural registers tracked (power of 2)
- REG_W, 3, register ID width, log2(NUM_REGS)
- LAT_W, 3, width of fixed-latency countdown per register

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- disp_valid  input  1  dispatch request this cycle
- disp_src0  input  REG_W  source register 0
- disp_src1  input  REG_W  source register 1
- disp_dst  input  REG_W  destination register
- disp_wr  input  1  instruction writes disp_dst
- disp_lat  input  LAT_W  result latency in cycles; 0 = variable latency (completes via wb)
- disp_ready  output  1  dispatch may be accepted this cycle (combinational)
- wb_valid  input  1  variable-latency writeback completes
- wb_dst  input  REG_W  register completed by wb
- busy  output  NUM_REGS  per-register pending-write vector (registered)
- wakeup  output  NUM_REGS  per-register completion pulse (combinational)
- wb_err  output  1  sticky: wb to a non-pending or fixed-latency register

Behaviour:
- Reset (reset_n=0 at edge): all busy=0, all counters=0, var flags=0, wb_err=0. wakeup=0 and disp_ready=1 follow from state. Reset mid-flight discards all pending writes. No wakeups are issued for discarded writes.
- Per-register state:
  - busy bit
  - LAT_W counter
  - var flag (pending write is variable latency)
- Register 0 is hardwired free: busy[0]=0 always, never stalls, writes to it are ignored.
- disp_ready = !busy[disp_src0] && !busy[disp_src1] && !(disp_wr && busy[disp_dst]).
  - Uses registered busy only; no same-cycle bypass of a completing write.
  - disp_ready is valid regardless of disp_valid.
- Accept = disp_valid && disp_ready. On accept with disp_wr and disp_dst!=0:
  - disp_lat>0: busy=1, counter=disp_lat, var=0 next cycle.
  - disp_lat==0: busy=1, var=1, counter untouched.
- Fixed-latency completion: each cycle a busy, non-var register with counter>1 decrements. When counter==1, wakeup[r]=1 that cycle and busy/counter clear at the edge.
  - Result: busy is high for exactly disp_lat cycles after the accept edge.
- Variable completion: wb_valid && busy[wb_dst] && var[wb_dst] gives wakeup[wb_dst]=1 that cycle; busy and var clear at the edge.
- Error: wb_valid to a register that is not busy, is fixed-latency, or is reg 0 sets wb_err=1 (sticky until reset). State is unchanged.
- Simultaneous events:
  - A completion and a new accept targeting the same dst cannot coincide, because disp_ready is 0 while dst is busy.
  - Completion of a source in cycle N: disp_ready stays 0 in N and rises in N+1.
  - Multiple fixed-latency completions plus one wb in the same cycle are allowed; all the corresponding wakeup bits assert together.
- Throughput: one dispatch per cycle. Back-to-back independent dispatches accept every cycle.

Decomposition:
- Shared package holds:
  - REG_W, NUM_REGS
  - the reg_id_t typedef (shared with the issue window)
  - the LAT_VAR=0 encoding constant
- One natural sub-module, sb_entry: a single register's busy/var/counter state and its wakeup/clear logic, instantiated NUM_REGS-1 times by generate (entry 0 tied off).
- Top level holds the disp_ready mux logic, dst/wb decode and wb_err.

Test Plan:
- Reset then disp_valid=1, src0=1, src1=2, dst=3, wr=1, lat=2 -> disp_ready=1, accepted. busy[3]=1 for 2 cycles, wakeup[3] pulses in the 2nd cycle, busy[3]=0 after.
- Dispatch dst=5, lat=3, then next cycle src0=5 -> disp_ready=0 for 3 cycles. disp_ready=1 in the cycle after wakeup[5], and the consumer is accepted then.
- Dispatch dst=4, lat=0; hold 10 cycles -> busy[4] stays 1. Then wb_valid=1, wb_dst=4 -> wakeup[4]=1 that cycle, busy[4]=0 next, wb_err=0.
- wb_valid=1, wb_dst=6 with reg 6 idle -> wb_err=1 and stays 1; busy unchanged. Then reset_n=0 one cycle -> wb_err=0.
- Dispatch dst=0, lat=4 -> busy=0 throughout, no wakeup. Then dispatch dst=7 twice back-to-back (lat=1) -> 2nd stalls one cycle (WAW), accepted the cycle after wakeup[7].
- Pending dst=2 (lat=7) and dst=3 (lat=0); assert reset_n=0 mid-count -> busy=0 next cycle, no wakeups afterwards, disp_ready=1.
